// File: rtl/key_sw_io_pkg.sv
// Shared register map and control-word layout for the key/switch input peripheral.
package io_defs;

  localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] SDATA_ADDR = 32'hF000_0014;
  localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;
  localparam logic [31:0] SCTRL_ADDR = 32'hF000_0114;

  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 2;
  localparam int IE_BIT      = 8;

  function automatic logic [31:0] ctrl_word(input logic ready, input logic overrun,
                                            input logic ie);
    ctrl_word              = '0;
    ctrl_word[READY_BIT]   = ready;
    ctrl_word[OVERRUN_BIT] = overrun;
    ctrl_word[IE_BIT]      = ie;
  endfunction

endpackage

// File: rtl/io_input_channel.sv
// One input channel: 2-flop synchronizer, optional debounce counter, data register
// and the ready/overrun/ie status bits.
module io_input_channel #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_clr,
  input  logic             ctrl_we,
  input  logic             wr_ovr,
  input  logic             wr_ie,
  output logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             overrun,
  output logic             ie
);

  logic [WIDTH-1:0] sync1, sync2;
  logic             load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign load = (sync2 != data);
    end else begin : g_debounce
      localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
      logic [CW-1:0] cnt;

      // sync1 != sync2 means the settled value is about to change: restart the count
      assign load = (sync2 != data) && (sync1 == sync2) && (cnt == CW'(DEBOUNCE - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt <= '0;
        else if (sync2 == data || sync1 != sync2 || load)
          cnt <= '0;
        else
          cnt <= cnt + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (load)
        data <= sync2;
      // a new event outranks a same-edge read clear
      if (load)
        ready <= 1'b1;
      else if (rd_clr)
        ready <= 1'b0;
      if (load && ready && !rd_clr)
        overrun <= 1'b1;
      else if (ctrl_we && !wr_ovr)
        overrun <= 1'b0;
      if (ctrl_we)
        ie <= wr_ie;
    end
  end

endmodule

// File: rtl/key_sw_io.sv
// Memory-mapped key/switch input peripheral: address decode, combinational read mux
// and registered interrupt around two input channels.
module key_sw_io
  import io_defs::*;
#(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_in,
  input  logic [9:0]       sw_in,
  input  logic [DBITS-1:0] addr,
  input  logic             re,
  input  logic             we,
  input  logic [DBITS-1:0] wdata,
  output logic             sel,
  output logic [DBITS-1:0] rdata,
  output logic             irq
);

  logic hit_kd, hit_sd, hit_kc, hit_sc;
  logic [3:0] kdata;
  logic [9:0] sdata;
  logic k_ready, k_ovr, k_ie;
  logic s_ready, s_ovr, s_ie;
  logic unused_wdata;

  assign hit_kd = (addr == DBITS'(KDATA_ADDR));
  assign hit_sd = (addr == DBITS'(SDATA_ADDR));
  assign hit_kc = (addr == DBITS'(KCTRL_ADDR));
  assign hit_sc = (addr == DBITS'(SCTRL_ADDR));
  assign sel    = hit_kd | hit_sd | hit_kc | hit_sc;

  // only the overrun and ie bits of a store matter
  assign unused_wdata = ^wdata;

  io_input_channel #(.WIDTH(4), .DEBOUNCE(0)) u_keys (
    .clk     (clk),
    .rst_n   (reset),
    .din     (key_in),
    .rd_clr  (re & hit_kd),
    .ctrl_we (we & hit_kc),
    .wr_ovr  (wdata[OVERRUN_BIT]),
    .wr_ie   (wdata[IE_BIT]),
    .data    (kdata),
    .ready   (k_ready),
    .overrun (k_ovr),
    .ie      (k_ie)
  );

  io_input_channel #(.WIDTH(10), .DEBOUNCE(DEBOUNCE_CYCLES)) u_sw (
    .clk     (clk),
    .rst_n   (reset),
    .din     (sw_in),
    .rd_clr  (re & hit_sd),
    .ctrl_we (we & hit_sc),
    .wr_ovr  (wdata[OVERRUN_BIT]),
    .wr_ie   (wdata[IE_BIT]),
    .data    (sdata),
    .ready   (s_ready),
    .overrun (s_ovr),
    .ie      (s_ie)
  );

  always_comb begin
    rdata = '0;
    if (hit_kd)      rdata = DBITS'(kdata);
    else if (hit_sd) rdata = DBITS'(sdata);
    else if (hit_kc) rdata = DBITS'(ctrl_word(k_ready, k_ovr, k_ie));
    else if (hit_sc) rdata = DBITS'(ctrl_word(s_ready, s_ovr, s_ie));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (k_ready & k_ie) | (s_ready & s_ie);
  end

endmodule
